// File: rtl/fifo_wr.sv
// Write-side pointer/flag controller of the async FIFO (w_clk domain).
// Define FIFO_WR_ALMOST_FULL_EN to build the registered almost-full flag.
module fifo_wr #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 4,
    parameter int AF_THRESH  = 6
) (
    input  logic                 w_clk,
    input  logic                 w_rstn,
    input  logic                 w_inc,
    input  logic [PTR_WIDTH-1:0] sync_rd_ptr,
    input  logic                 w_ovf_clr,
    output logic                 w_full,
    output logic                 w_en,
    output logic [PTR_WIDTH-2:0] w_addr,
    output logic [PTR_WIDTH-1:0] gray_wr_ptr,
    output logic [PTR_WIDTH-1:0] w_level,
    output logic                 w_ovf,
    output logic                 w_afull
);

    localparam int DEPTH = 1 << (PTR_WIDTH - 1);

    if (PTR_WIDTH < 3) begin : g_bad_ptr_width
        $error("fifo_wr: PTR_WIDTH must be >= 3");
    end
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("fifo_wr: DATA_WIDTH must be >= 1");
    end
    if (AF_THRESH < 1 || AF_THRESH >= DEPTH) begin : g_bad_af_thresh
        $warning("fifo_wr: AF_THRESH outside 1..depth-1");
    end

    logic [PTR_WIDTH-1:0] w_ptr;
    logic [PTR_WIDTH-1:0] ptr_next;
    logic [PTR_WIDTH-1:0] rd_bin;
    logic [PTR_WIDTH-1:0] full_cmp;

    // Full when the Gray pointers differ only in their top two bits.
    assign full_cmp = {~sync_rd_ptr[PTR_WIDTH-1 -: 2], sync_rd_ptr[PTR_WIDTH-3:0]};
    assign w_full   = (gray_wr_ptr == full_cmp);
    assign w_en     = w_inc & ~w_full;
    assign w_addr   = w_ptr[PTR_WIDTH-2:0];
    assign ptr_next = w_ptr + PTR_WIDTH'(1);

    always_comb begin
        rd_bin = '0;
        for (int i = 0; i < PTR_WIDTH; i++) begin
            rd_bin[i] = ^(sync_rd_ptr >> i);
        end
    end

    assign w_level = w_ptr - rd_bin;

    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            w_ptr       <= '0;
            gray_wr_ptr <= '0;
        end else if (w_en) begin
            w_ptr       <= ptr_next;
            gray_wr_ptr <= ptr_next ^ (ptr_next >> 1);
        end
    end

    // A write attempt at full outranks a same-cycle clear.
    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            w_ovf <= 1'b0;
        end else if (w_inc & w_full) begin
            w_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            w_ovf <= 1'b0;
        end
    end

`ifdef FIFO_WR_ALMOST_FULL_EN
    logic [PTR_WIDTH-1:0] next_level;

    assign next_level = w_level + {{(PTR_WIDTH-1){1'b0}}, w_en};

    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            w_afull <= 1'b0;
        end else begin
            w_afull <= (next_level >= PTR_WIDTH'(AF_THRESH));
        end
    end
`else
    assign w_afull = 1'b0;
`endif

endmodule

// File: doc/fifo_wr.md
Name: fifo_wr

Overview:
Write-side pointer and flag controller of the asynchronous FIFO, running in the write clock domain. Advances the binary write pointer on accepted writes and drives the memory write address and write strobe. Publishes a Gray-coded write pointer for synchronisation into the read domain. Computes the full flag, fill level and sticky overflow flag against the read pointer synchronised into this domain.

Parameters:
DATA_WIDTH, 8, data width of the FIFO; not used internally, kept for uniform instantiation with the read side
PTR_WIDTH, 4, pointer width including the wrap bit; depth = 2^(PTR_WIDTH-1); must be >= 3
AF_THRESH, 6, almost-full level in entries (1..depth-1); used only when FIFO_WR_ALMOST_FULL_EN is defined

Ports:
w_clk  input  1  write-domain clock, rising edge
w_rstn  input  1  asynchronous active-low reset
w_inc  input  1  write request from producer
sync_rd_ptr  input  PTR_WIDTH  Gray read pointer, already two-flop synchronised into w_clk
w_ovf_clr  input  1  synchronous clear of w_ovf
w_full  output  1  FIFO full
w_en  output  1  memory write strobe (accepted write)
w_addr  output  PTR_WIDTH-1  memory write address
gray_wr_ptr  output  PTR_WIDTH  registered Gray write pointer, to the read-domain synchroniser
w_level  output  PTR_WIDTH  fill level as seen by the write side, 0..depth
w_ovf  output  1  sticky: a write was attempted while full
w_afull  output  1  almost full (feature-dependent, see Optional Feature)

Behaviour:
- Reset (w_rstn low, asynchronous): binary pointer w_ptr=0, gray_wr_ptr=0, w_ovf=0, w_afull=0. Combinational outputs follow: w_addr=0, w_en=0. w_full=0 and w_level=0 when sync_rd_ptr=0.
- Accept rule: w_en = w_inc & ~w_full, combinational, same cycle. w_addr = w_ptr[PTR_WIDTH-2:0]. Memory writes at w_addr on that rising edge.
- On a w_clk edge with w_en=1: w_ptr <= w_ptr+1, modulo 2^PTR_WIDTH. gray_wr_ptr <= next ^ (next>>1), registered in the same edge. No glitches on gray_wr_ptr; at most one bit changes per increment.
- Invariant: gray_wr_ptr == w_ptr ^ (w_ptr>>1) at all times.
- Full: w_full = (gray_wr_ptr == {~sync_rd_ptr[MSB:MSB-1], sync_rd_ptr[MSB-2:0]}). Combinational from registers and the synchronised input. Pessimistic: it may stay asserted for up to 2 w_clk cycles after reads free space, and never under-reports.
- Level: rd_bin = Gray-to-binary of sync_rd_ptr (XOR prefix from MSB). w_level = (w_ptr - rd_bin) mod 2^PTR_WIDTH. Equals depth exactly when w_full=1.
- Overflow: on an edge with w_inc & w_full, w_ovf <= 1. Otherwise, if w_ovf_clr=1, w_ovf <= 0. Set wins over clear in the same cycle. A rejected write leaves pointer, address and memory unchanged.
- Wrap-around: after 2^PTR_WIDTH accepted writes, w_ptr returns to 0. The wrap bit toggles every depth writes. Full and empty detection stay correct across the wrap.
- Mid-operation reset: pointers return to 0 immediately, without waiting for a clock. The system resets both FIFO domains together; no partial-reset recovery is required.

Optional Feature:
Macro FIFO_WR_ALMOST_FULL_EN.
- Defined: w_afull is a register updated every edge, w_afull <= (next_level >= AF_THRESH). next_level is w_level after the current cycle's accepted write. Reset value 0.
- Not defined: w_afull is tied to 0 and AF_THRESH is unused.

Test Plan:
- Reset then idle, sync_rd_ptr=0 -> w_full=0, w_level=0, w_addr=0, gray_wr_ptr=0000, w_ovf=0.
- 8 back-to-back w_inc, sync_rd_ptr=0 (default params) -> w_addr 0..7, gray_wr_ptr 0001,0011,0010,0110,0111,0101,0100,1100. After 8th write: w_full=1, w_level=8.
- While full, pulse w_inc 1 cycle -> w_en=0, pointer unchanged, w_ovf=1. w_ovf_clr with w_inc=0 -> w_ovf=0. w_ovf_clr together with w_inc at full -> w_ovf stays 1.
- From full (gray_wr_ptr=1100), set sync_rd_ptr=0001 (one read) -> w_full=0, w_level=7. Next write -> w_addr=0, gray_wr_ptr=1101, w_full=1.
- Stream 40 writes with sync_rd_ptr tracking gray_wr_ptr 2 cycles late -> w_full never asserts, pointer wraps twice, at most 1 bit of gray_wr_ptr changes per cycle.
- With FIFO_WR_ALMOST_FULL_EN and AF_THRESH=6, sync_rd_ptr=0, write 6 -> w_afull rises on the edge of the 6th write. Without the macro -> w_afull=0 throughout.
